// File: rtl/sha256_pkg.sv
// sha256_pkg: shared states and address defaults for the SHA-256 host controller and hasher.
package sha256_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ, DRAIN, ERROR} state_e;
  localparam int HASH_WORDS = 8;
  localparam logic [15:0] DEF_INPUT_ADDR = 16'h0000;
  localparam logic [15:0] DEF_HASH_ADDR = 16'h0100;
  function automatic logic sha_owns_mem(state_e s);
    return s inside {START, WAIT_BUSY, WAIT_DONE};
  endfunction
endpackage

// File: rtl/sha256_mem_mux.sv
// sha256_mem_mux: selects whether the hasher or the controller drives the shared memory port.
module sha256_mem_mux (
  input  logic        sha_own,
  input  logic [15:0] ctl_addr,
  input  logic        ctl_we,
  input  logic [31:0] ctl_wdata,
  input  logic [15:0] sha_addr,
  input  logic        sha_we,
  input  logic [31:0] sha_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);
  assign mem_addr  = sha_own ? sha_addr  : ctl_addr;
  assign mem_we    = sha_own ? sha_we    : ctl_we;
  assign mem_wdata = sha_own ? sha_wdata : ctl_wdata;
endmodule

// File: rtl/sha256_host_ctrl.sv
// sha256_host_ctrl: streams a message into shared memory, runs the hasher, and streams the hash back out.
module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 40,
  parameter logic [15:0] INPUT_ADDR   = DEF_INPUT_ADDR,
  parameter logic [15:0] HASH_ADDR    = DEF_HASH_ADDR,
  parameter int          TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        error,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] sha_input_addr,
  output logic [15:0] sha_hash_addr,
  input  logic [15:0] sha_mem_addr,
  input  logic        sha_mem_we,
  input  logic [31:0] sha_mem_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic [3:0]  rd_q, rd_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] hbuf_q [HASH_WORDS];
  logic [31:0] hbuf_d [HASH_WORDS];
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [31:0] out_data_q, out_data_d;
  logic        sha_start_q, sha_start_d, busy_q, busy_d, error_q, error_d;
  logic [15:0] ctl_addr_q, ctl_addr_d;
  logic        ctl_we_q, ctl_we_d;
  logic [31:0] ctl_wdata_q, ctl_wdata_d;
  logic        hs_in, hs_out, wdog_exp;

  assign hs_in    = in_valid && in_ready_q;
  assign hs_out   = out_valid_q && out_ready;
  assign wdog_exp = wdog_q >= 32'(TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdog_d      = wdog_q;
    rd_d        = rd_q;
    n_d         = n_q;
    hbuf_d      = hbuf_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    sha_start_d = 1'b0;
    ctl_addr_d  = ctl_addr_q;
    ctl_we_d    = 1'b0;
    ctl_wdata_d = ctl_wdata_q;
    case (state_q)
      IDLE: if (hs_in) begin
        state_d     = LOAD;
        cnt_d       = 16'd1;
        ctl_addr_d  = INPUT_ADDR;
        ctl_we_d    = 1'b1;
        ctl_wdata_d = in_data;
      end
      // One extra LOAD cycle after the last word lets its write land before the hasher owns memory.
      LOAD: if (hs_in) begin
        ctl_addr_d  = INPUT_ADDR + cnt_q;
        ctl_we_d    = 1'b1;
        ctl_wdata_d = in_data;
        cnt_d       = cnt_q + 16'd1;
      end else if (!in_ready_q) begin
        state_d     = START;
        sha_start_d = 1'b1;
      end
      START: begin
        state_d = WAIT_BUSY;
        wdog_d  = '0;
      end
      WAIT_BUSY: begin
        wdog_d  = wdog_q + 32'd1;
        state_d = wdog_exp ? ERROR : (!sha_done ? WAIT_DONE : WAIT_BUSY);
      end
      WAIT_DONE: begin
        wdog_d     = wdog_q + 32'd1;
        state_d    = wdog_exp ? ERROR : (sha_done ? READ : WAIT_DONE);
        ctl_addr_d = HASH_ADDR;
        rd_d       = '0;
      end
      // rd_q counts READ cycles: addresses go out on 0..7, data is captured on 1..8.
      READ: begin
        rd_d = rd_q + 4'd1;
        if (rd_q < 4'd7) ctl_addr_d = HASH_ADDR + 16'(rd_q) + 16'd1;
        if (rd_q != 4'd0) hbuf_d[3'(rd_q - 4'd1)] = mem_rdata;
        if (rd_q == 4'd8) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          out_data_d  = hbuf_q[0];
          out_last_d  = 1'b0;
          n_d         = '0;
        end
      end
      DRAIN: if (hs_out) begin
        if (n_q == 3'd7) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          n_d        = n_q + 3'd1;
          out_data_d = hbuf_q[n_q + 3'd1];
          out_last_d = n_q == 3'd6;
        end
      end
      ERROR: ;
    endcase
    in_ready_d = state_d == IDLE || (state_d == LOAD && cnt_d < 16'(NUM_OF_WORDS));
    busy_d     = !(state_d inside {IDLE, ERROR});
    error_d    = state_d == ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdog_q      <= '0;
      rd_q        <= '0;
      n_q         <= '0;
      hbuf_q      <= '{default: '0};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      sha_start_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_we_q    <= 1'b0;
      ctl_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      rd_q        <= rd_d;
      n_q         <= n_d;
      hbuf_q      <= hbuf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      sha_start_q <= sha_start_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_we_q    <= ctl_we_d;
      ctl_wdata_q <= ctl_wdata_d;
    end
  end

  sha256_mem_mux u_mux (
    .sha_own   (sha_owns_mem(state_q)),
    .ctl_addr  (ctl_addr_q),
    .ctl_we    (ctl_we_q),
    .ctl_wdata (ctl_wdata_q),
    .sha_addr  (sha_mem_addr),
    .sha_we    (sha_mem_we),
    .sha_wdata (sha_mem_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign busy           = busy_q;
  assign error          = error_q;
  assign sha_start      = sha_start_q;
  assign sha_input_addr = INPUT_ADDR;
  assign sha_hash_addr  = HASH_ADDR;
endmodule

// File: tb/tb_sha256_host_ctrl.sv
// tb_sha256_host_ctrl: drives messages through the controller against a stub hasher and a registered memory.
module tb_sha256_host_ctrl;
  localparam int N  = 40;
  localparam int TO = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, busy, error, sha_start;
  logic [31:0] in_data = '0, out_data, mem_wdata, mem_rdata;
  logic        sha_done, sha_mem_we, mem_we;
  logic [15:0] sha_input_addr, sha_hash_addr, sha_mem_addr, mem_addr;
  logic [31:0] sha_mem_wdata;

  int          errors = 0, checks = 0, cyc = 0, starts = 0, stub_cnt = 0;
  bit          hang = 1'b0;
  logic [31:0] hash_base = 32'h1000_0000;
  logic [31:0] mem [0:511];
  logic [31:0] words [N];
  logic [31:0] sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_host_ctrl #(.NUM_OF_WORDS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .error(error),
    .sha_start(sha_start), .sha_done(sha_done),
    .sha_input_addr(sha_input_addr), .sha_hash_addr(sha_hash_addr),
    .sha_mem_addr(sha_mem_addr), .sha_mem_we(sha_mem_we), .sha_mem_wdata(sha_mem_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[8:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[8:0]];
  end

  // Stub hasher: drops done, writes hash_base+k to 0x100+k, raises done. Noise on sha_mem_* while the controller loads.
  always @(posedge clk) begin
    if (rst) begin
      stub_cnt <= 0; sha_done <= 1'b1; sha_mem_we <= 1'b0; sha_mem_addr <= '0; sha_mem_wdata <= '0;
    end else if (stub_cnt == 0) begin
      sha_mem_we    <= in_ready ? 1'($urandom) : 1'b0;
      sha_mem_addr  <= 16'($urandom);
      sha_mem_wdata <= $urandom;
      if (sha_start) begin
        starts <= starts + 1;
        if (!hang) begin stub_cnt <= 1; sha_done <= 1'b0; end
      end
    end else begin
      stub_cnt      <= stub_cnt + 1;
      sha_mem_we    <= stub_cnt >= 4 && stub_cnt < 12;
      sha_mem_addr  <= 16'h0100 + 16'(stub_cnt - 4);
      sha_mem_wdata <= hash_base + 32'(stub_cnt - 4);
      if (stub_cnt == 13) begin sha_done <= 1'b1; stub_cnt <= 0; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_msg(input int nw);
    for (int k = 0; k < nw; k++) begin
      int w = 0;
      words[k] = $urandom; in_valid = 1'b1; in_data = words[k];
      while (!in_ready && w < 50) begin tick(); w++; end
      tick();
      checks++;
      if (w >= 50 || mem_we !== 1'b1 || mem_addr !== 16'(k) || mem_wdata !== words[k]) begin
        errors++;
        $display("FAIL load_write k=%0d: got we=%b addr=%h data=%h, want we=1 addr=%h data=%h", k, mem_we, mem_addr, mem_wdata, 16'(k), words[k]);
      end
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic run_full(input bit bp);
    int s0 = starts, t_done = -1, t_ov = -1, n = 0, bad = 0;
    bit seen_low = 0, stall = 0;
    logic [31:0] pd, ex;
    logic pl;
    for (int i = 0; i < 8; i++) sbq.push_back(hash_base + 32'(i));
    load_msg(N);
    checks++;
    if (in_ready !== 1'b0 || sha_start !== 1'b0) begin errors++; $display("FAIL after_load: in_ready=%b sha_start=%b, want 0 0", in_ready, sha_start); end
    tick();
    checks++;
    if (sha_start !== 1'b1) begin errors++; $display("FAIL start_timing: sha_start=%b, want 1", sha_start); end
    tick();
    checks++;
    if (sha_start !== 1'b0) begin errors++; $display("FAIL start_width: sha_start=%b, want 0", sha_start); end
    for (int c = 0; c < 300 && !out_valid; c++) begin
      if (!sha_done) seen_low = 1;
      else if (seen_low && t_done < 0) t_done = cyc;
      if (sha_mem_we) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== sha_mem_addr || mem_wdata !== sha_mem_wdata) begin
          errors++; $display("FAIL sha_owner: got %b %h %h, want 1 %h %h", mem_we, mem_addr, mem_wdata, sha_mem_addr, sha_mem_wdata);
        end
      end
      tick();
    end
    t_ov = cyc;
    checks++;
    if (out_valid !== 1'b1 || t_ov - t_done != 10) begin
      errors++; $display("FAIL read_latency: out_valid=%b cycles done->valid=%0d, want 1 and 10", out_valid, t_ov - t_done);
    end
    for (int c = 0; c < 100 && n < 8; c++) begin
      out_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          errors++; $display("FAIL hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b", out_valid, out_data, out_last, pd, pl);
        end
      end
      if (out_valid && out_ready) begin
        ex = sbq.size() > 0 ? sbq.pop_front() : 32'hx;
        checks++;
        if (out_data !== ex || out_last !== (n == 7)) begin
          errors++; $display("FAIL hash_word n=%0d: got %h last=%b, want %h last=%b", n, out_data, out_last, ex, n == 7);
        end
        n++;
      end
      stall = out_valid && !out_ready; pd = out_data; pl = out_last;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (n != 8) begin errors++; $display("FAIL drain_count: got %0d words, want 8", n); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_drain: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
    checks++;
    if (starts - s0 != 1) begin errors++; $display("FAIL start_count: got %0d, want 1", starts - s0); end
    for (int k = 0; k < N; k++) if (mem[k] !== words[k]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mem_contents: %0d bad words, want 0", bad); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if ({in_ready, out_valid, out_last, sha_start, mem_we, busy, error} !== 7'b0 || out_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_values: rdy=%b ov=%b ol=%b st=%b we=%b busy=%b err=%b od=%h ma=%h md=%h, want all 0",
        in_ready, out_valid, out_last, sha_start, mem_we, busy, error, out_data, mem_addr, mem_wdata);
    end
    rst = 1'b0; tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy); end
  endtask

  task automatic test_stub_40();
    hash_base = 32'h1000_0000;
    run_full(1'b0);
  endtask

  task automatic test_backpressure();
    hash_base = $urandom;
    run_full(1'b1);
  endtask

  task automatic test_back_to_back();
    hash_base = $urandom;
    run_full(1'b0);
    hash_base = $urandom;
    run_full(1'b1);
  endtask

  task automatic test_timeout();
    int ts, ov = 0;
    hang = 1'b1;
    load_msg(N);
    tick();
    ts = cyc;
    checks++;
    if (sha_start !== 1'b1) begin errors++; $display("FAIL timeout_start: sha_start=%b, want 1", sha_start); end
    for (int c = 0; c < TO + 50 && !error; c++) begin if (out_valid) ov++; tick(); end
    checks++;
    if (error !== 1'b1 || cyc - ts != TO + 1) begin
      errors++; $display("FAIL timeout_time: error=%b after %0d cycles, want 1 after %0d", error, cyc - ts, TO + 1);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || ov != 0) begin
      errors++; $display("FAIL timeout_outputs: busy=%b in_ready=%b out_valid_cycles=%0d, want 0 0 0", busy, in_ready, ov);
    end
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL error_sticky: error=%b in_ready=%b out_valid=%b, want 1 0 0", error, in_ready, out_valid);
    end
    rst = 1'b1; tick(); rst = 1'b0; hang = 1'b0; tick();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL error_clear: error=%b in_ready=%b, want 0 1", error, in_ready); end
  endtask

  task automatic test_reset_mid_load();
    load_msg(5);
    rst = 1'b1; tick();
    checks++;
    if ({in_ready, out_valid, sha_start, mem_we, busy, error} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL mid_reset: rdy=%b ov=%b st=%b we=%b busy=%b err=%b ma=%h md=%h, want all 0",
        in_ready, out_valid, sha_start, mem_we, busy, error, mem_addr, mem_wdata);
    end
    rst = 1'b0; tick();
    hash_base = $urandom;
    run_full(1'b0);
  endtask

  initial begin
    test_reset();
    test_stub_40();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_host_ctrl.md
# sha256_host_ctrl

Host-side controller for the simplified SHA-256 hasher. It accepts a message as a stream of 32-bit words and writes them into the shared word memory. It then starts the hasher, waits for completion, and returns the 8 hash words from memory as an output stream. It sits between the system stream fabric and the hasher, and owns the single memory port except while the hasher runs.

## Interface
Parameters:
- NUM_OF_WORDS, 40: message length in words; must match the hasher instance.
- INPUT_ADDR, 16'h0000: first memory word of the message.
- HASH_ADDR, 16'h0100: first memory word of the hash output.
- TIMEOUT, 4096: maximum cycles to wait for the hasher.

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  message word valid
- in_ready  out  1  controller accepts a message word
- in_data  in  32  message word
- out_valid  out  1  hash word valid
- out_ready  in  1  sink accepts a hash word
- out_data  out  32  hash word; hash0 first
- out_last  out  1  high with the 8th hash word
- busy  out  1  high in every state except IDLE and ERROR
- error  out  1  hasher timeout; sticky
- sha_start  out  1  one-cycle start pulse to the hasher
- sha_done  in  1  hasher done; high whenever the hasher is idle
- sha_input_addr  out  16  constant INPUT_ADDR
- sha_hash_addr  out  16  constant HASH_ADDR
- sha_mem_addr  in  16  hasher memory address
- sha_mem_we  in  1  hasher write enable
- sha_mem_wdata  in  32  hasher write data
- mem_addr  out  16  memory address after the mux
- mem_we  out  1  memory write enable after the mux
- mem_wdata  out  32  memory write data after the mux
- mem_rdata  in  32  memory read data; one-cycle registered read latency; also wired to the hasher at top level

## Operation
- **Memory ownership.** The hasher side drives mem_* combinationally in START, WAIT_BUSY and WAIT_DONE. In all other states the controller's registered request drives mem_*.
- **IDLE.** in_ready=1. The first in handshake moves to LOAD, with that word counted as word 0.
- **LOAD.** in_ready=1 while word count < NUM_OF_WORDS.
  - Handshake k registers mem_addr=INPUT_ADDR+k, mem_we=1, mem_wdata=in_data, so the write lands the next cycle.
  - After word NUM_OF_WORDS-1: in_ready drops and the state goes to START.
- **START.** sha_start=1 for exactly one cycle, then WAIT_BUSY. Watchdog cleared.
- **WAIT_BUSY.** Wait for sha_done=0, then WAIT_DONE.
  - sha_done must be ignored in the cycle sha_start is issued.
- **WAIT_DONE.** Wait for sha_done=1, then READ.
- **Watchdog.** Counts every cycle in WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT sends the state to ERROR.
- **READ.** Issue reads to HASH_ADDR+0..7 on consecutive cycles. Capture mem_rdata one cycle after each address into an 8×32 buffer. After the 8th capture, go to DRAIN.
- **DRAIN.** out_valid=1 and out_data=buffer[n].
  - Each out handshake increments n.
  - out_last=(n==7).
  - The handshake on n==7 returns the block to IDLE.
- **ERROR.** error=1, in_ready=0, out_valid=0. The controller keeps ownership of the memory port. Exits only on rst.
- **Counters.** Word counter is 16-bit; address arithmetic is 16-bit and wraps modulo 2^16.
- **Stream rules.** in_valid in any state other than IDLE or LOAD is left pending (not accepted). out_data/out_last hold stable while out_valid=1 and out_ready=0.

## Timing
- **Reset values:** state IDLE; in_ready 0 during rst, then 1 the cycle after rst deasserts; out_valid 0; out_last 0; out_data 0; sha_start 0; mem_we 0; mem_addr 0; mem_wdata 0; busy 0; error 0.
- **Rst mid-operation** (any state) returns to IDLE next cycle. Buffer contents and word count are discarded; no partial write persists beyond an already-issued mem_we.
- **Load rate:** one word per cycle at full throughput; last memory write occurs 1 cycle after the last in handshake.
- **sha_start** asserts 2 cycles after the last in handshake.
- **READ to DRAIN:** first out_valid 9 cycles after entering READ.
- **Minimum overhead** beyond hasher time: NUM_OF_WORDS + 2 + 9 + 8 cycles.
- **Back-to-back messages:** in_ready returns the cycle after the final out handshake.

## Structure
- Shared package sha256_pkg:
  - state enum {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ, DRAIN, ERROR}
  - HASH_WORDS=8
  - default address constants
- Sub-module sha256_mem_mux: combinational ownership select for mem_addr/mem_we/mem_wdata.
- FSM, counters and hash buffer live in the top.

## Test plan
- **Real hasher, 1-word message.** Configure NUM_OF_WORDS=1 and send 32'h61626364 ("abcd"). The output stream must be 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589, with out_last on the 8th word.
- **Stub hasher, 40 words.** Stream 40 words at full rate; the stub writes 32'h1000_0000+k to HASH_ADDR+k. Check:
  - memory holds the input words at 0..39
  - exactly one sha_start pulse
  - output is 10000000..10000007
- **Backpressure.** out_ready toggles 1,0,0,1 repeating. out_data must hold while stalled, and no word may be lost or duplicated.
- **Timeout.** Stub never drops sha_done. error=1 and busy=0 after TIMEOUT cycles; no out_valid ever.
- **Reset mid-LOAD.** Assert rst after 5 words. Check reset values, then a full 40-word message completes correctly.
- **Ownership.** During WAIT_DONE, stub writes with sha_mem_we=1 must appear on mem_*. In LOAD, random sha_mem_* values must never appear on mem_*.
